irst_controller: RTL and testbench

IRST_CONTROLLER -- requirements
Module: irst_controller

---
 rtl/irst_controller_pkg.sv | 17 +
 rtl/irst_controller_pattern_gen.sv | 16 +
 rtl/irst_controller.sv | 147 ++++++++++++++
 tb/tb_irst_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irst_controller_pkg.sv
// Shared definitions for the register-file self-test controller:
// state encoding, start-bit position and the tested address range.
package irst_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_CHECK = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int         START_BIT  = 15;
  localparam logic [2:0] ADDR_FIRST = 3'd1;
  localparam logic [2:0] ADDR_LAST  = 3'd7;

endpackage

// File: rtl/irst_controller_pattern_gen.sv
// Combinational test-pattern generator: P = {S,S} on pass 0, ~{S,S} on
// pass 1, and the expected word for address A is P with A folded into
// the low bits so every entry holds a distinct value.
module irst_pattern_gen (
  input  logic [7:0]  seed,
  input  logic        pass,
  input  logic [2:0]  addr,
  output logic [15:0] expected
);

  logic [15:0] pattern;

  assign pattern  = pass ? ~{seed, seed} : {seed, seed};
  assign expected = pattern ^ {13'b0, addr};

endmodule

// File: rtl/irst_controller.sv
// Register-file self-test controller. On a start bit in entry 0 it takes
// over the register-file ports, writes and verifies two complementary
// patterns over entries 1..7, clears them, then pulses irst_done (which
// also clears entry 0). Outside a test the pipeline ports pass straight
// through to the register file.
module irst_controller
  import irst_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] irst_reg_data,
  output logic        irst_done,
  input  logic        pipe_write_en,
  input  logic [2:0]  pipe_write_dest,
  input  logic [15:0] pipe_write_data,
  input  logic [2:0]  pipe_read_addr_1,
  output logic        rf_write_en,
  output logic [2:0]  rf_write_dest,
  output logic [15:0] rf_write_data,
  output logic [2:0]  rf_read_addr_1,
  input  logic [15:0] rf_read_data_1,
  output logic        pipe_stall,
  output logic        irst_busy,
  output logic        irst_fail,
  output logic [2:0]  irst_fail_addr
);

  state_t      state_q, state_d;
  logic [2:0]  addr_q, addr_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [2:0]  fail_addr_q, fail_addr_d;
  logic [7:0]  seed_q, seed_d;
  logic [15:0] expected;
  logic        busy;
  logic        unused_reg_bits;

  // Only the start bit and the seed byte of entry 0 carry meaning.
  assign unused_reg_bits = ^irst_reg_data[14:8];

  irst_pattern_gen u_pattern_gen (
    .seed     (seed_q),
    .pass     (pass_q),
    .addr     (addr_q),
    .expected (expected)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; only the level of rst at a rising edge matters.
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= ADDR_FIRST;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= 3'd0;
      seed_q      <= 8'd0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      seed_q      <= seed_d;
    end
  end

  // Next-state, counter sequencing and mismatch capture.
  always_comb begin
    // NOTE: hold-value defaults first so no branch leaves a variable unassigned.
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    seed_d      = seed_q;
    unique case (state_q)
      ST_IDLE: begin
        if (irst_reg_data[START_BIT]) begin
          state_d     = ST_WRITE;
          addr_d      = ADDR_FIRST;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = 3'd0;
          seed_d      = irst_reg_data[7:0];
        end
      end
      ST_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          state_d = ST_CHECK;
          addr_d  = ADDR_FIRST;
        end else begin
          addr_d = addr_q + 3'd1;
        end
      end
      ST_CHECK: begin
        if (rf_read_data_1 != expected) begin
          fail_d = 1'b1;
          if (!fail_q) fail_addr_d = addr_q;
        end
        if (addr_q == ADDR_LAST) begin
          addr_d = ADDR_FIRST;
          if (pass_q) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_WRITE;
            pass_d  = 1'b1;
          end
        end else begin
          addr_d = addr_q + 3'd1;
        end
      end
      ST_CLEAR: begin
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DONE;
          addr_d  = ADDR_FIRST;
        end else begin
          addr_d = addr_q + 3'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Port steering: pipeline pass-through when idle or in reset, test drive otherwise.
  always_comb begin
    busy           = rst && (state_q != ST_IDLE);
    irst_busy      = busy;
    pipe_stall     = busy;
    irst_done      = rst && (state_q == ST_DONE);
    irst_fail      = fail_q;
    irst_fail_addr = fail_addr_q;
    rf_write_en    = pipe_write_en;
    rf_write_dest  = pipe_write_dest;
    rf_write_data  = pipe_write_data;
    rf_read_addr_1 = pipe_read_addr_1;
    if (busy) begin
      rf_write_en    = (state_q == ST_WRITE) || (state_q == ST_CLEAR);
      rf_write_dest  = addr_q;
      rf_write_data  = (state_q == ST_CLEAR) ? 16'h0000 : expected;
      rf_read_addr_1 = addr_q;
    end
  end

endmodule

// File: tb/tb_irst_controller.sv
// Self-checking bench for irst_controller: a behavioural register file
// with optional read-fault injection, randomized pipeline traffic and a
// cycle timeline of the test sequence derived from its phase rules.
module tb_irst_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irst_reg_data;
  logic        irst_done;
  logic        pipe_write_en;
  logic [2:0]  pipe_write_dest;
  logic [15:0] pipe_write_data;
  logic [2:0]  pipe_read_addr_1;
  logic        rf_write_en;
  logic [2:0]  rf_write_dest;
  logic [15:0] rf_write_data;
  logic [2:0]  rf_read_addr_1;
  logic [15:0] rf_read_data_1;
  logic        pipe_stall;
  logic        irst_busy;
  logic        irst_fail;
  logic [2:0]  irst_fail_addr;

  logic [15:0] mem [8];
  logic        rf_clear_req;
  logic        fault_active;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  irst_controller dut (
    .clk              (clk),
    .rst              (rst),
    .irst_reg_data    (irst_reg_data),
    .irst_done        (irst_done),
    .pipe_write_en    (pipe_write_en),
    .pipe_write_dest  (pipe_write_dest),
    .pipe_write_data  (pipe_write_data),
    .pipe_read_addr_1 (pipe_read_addr_1),
    .rf_write_en      (rf_write_en),
    .rf_write_dest    (rf_write_dest),
    .rf_write_data    (rf_write_data),
    .rf_read_addr_1   (rf_read_addr_1),
    .rf_read_data_1   (rf_read_data_1),
    .pipe_stall       (pipe_stall),
    .irst_busy        (irst_busy),
    .irst_fail        (irst_fail),
    .irst_fail_addr   (irst_fail_addr)
  );

  // Register file model: entry 0 is cleared by irst_done.
  always @(posedge clk) begin
    if (rf_clear_req) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
    end else begin
      if (rf_write_en) mem[rf_write_dest] <= rf_write_data;
      if (irst_done) mem[0] <= 16'h0000;
    end
  end

  assign irst_reg_data  = mem[0];
  assign rf_read_data_1 = (fault_active && rf_read_addr_1 == 3'd3)
                          ? (mem[rf_read_addr_1] & 16'hFFFE) : mem[rf_read_addr_1];

  function automatic logic [15:0] pattern_of(input logic [7:0] s, input int pass_num);
    return (pass_num == 0) ? {s, s} : ~{s, s};
  endfunction

  // Fault model: what the check passes should conclude.
  task automatic model_fail(input logic [7:0] s, input bit fault,
                            output logic f, output logic [2:0] fa);
    logic [15:0] e, o;
    f  = 1'b0;
    fa = 3'd0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 1; a <= 7; a++) begin
        e = pattern_of(s, p) ^ 16'(a);
        o = (fault && p == 0 && a == 3) ? (e & 16'hFFFE) : e;
        if (o != e && !f) begin
          f  = 1'b1;
          fa = 3'(a);
        end
      end
    end
  endtask

  // Starts at cycle 0 (start bit visible, controller idle) and follows the whole sequence.
  task automatic follow_sequence(input logic [7:0] s, input bit fault, input string tag);
    logic [2:0]  d0;
    logic [15:0] x0;
    logic        we_e, done_e, chk_e, exp_f, nz;
    logic [2:0]  dest_e, exp_fa;
    logic [15:0] dat_e;
    int          ph, a;
    d0 = 3'($urandom_range(1, 7));
    x0 = 16'($urandom);
    pipe_write_en    = 1'b1;
    pipe_write_dest  = d0;
    pipe_write_data  = x0;
    pipe_read_addr_1 = d0;
    #1;
    tests_run++;
    if ({irst_busy, pipe_stall, rf_write_en, rf_write_dest, rf_write_data, rf_read_addr_1}
        !== {2'b00, 1'b1, d0, x0, d0}) begin
      tests_failed++;
      $display("FAIL %s start_cycle_write: got busy=%b en=%b dest=%0d data=%h, expected busy=0 en=1 dest=%0d data=%h",
               tag, irst_busy, rf_write_en, rf_write_dest, rf_write_data, d0, x0);
    end
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      fault_active     = fault && (c >= 8) && (c <= 14);
      pipe_write_en    = 1'($urandom);
      pipe_write_dest  = 3'($urandom);
      pipe_write_data  = 16'($urandom);
      pipe_read_addr_1 = 3'($urandom);
      #1;
      we_e   = 1'b0;
      chk_e  = 1'b0;
      dest_e = 3'd0;
      dat_e  = 16'h0000;
      done_e = (c == 36);
      if (c <= 35) begin
        ph     = (c - 1) / 7;
        a      = (c - 1) % 7 + 1;
        dest_e = 3'(a);
        case (ph)
          0: begin we_e = 1'b1; dat_e = pattern_of(s, 0) ^ 16'(a); end
          2: begin we_e = 1'b1; dat_e = pattern_of(s, 1) ^ 16'(a); end
          4: begin we_e = 1'b1; dat_e = 16'h0000; end
          default: chk_e = 1'b1;
        endcase
      end
      tests_run++;
      if ({irst_busy, pipe_stall, irst_done, rf_write_en} !== {2'b11, done_e, we_e}) begin
        tests_failed++;
        $display("FAIL %s c%0d ctrl(busy,stall,done,we): got %b expected %b",
                 tag, c, {irst_busy, pipe_stall, irst_done, rf_write_en}, {2'b11, done_e, we_e});
      end
      if (we_e) begin
        tests_run++;
        if ({rf_write_dest, rf_write_data} !== {dest_e, dat_e}) begin
          tests_failed++;
          $display("FAIL %s c%0d write: got dest=%0d data=%h expected dest=%0d data=%h",
                   tag, c, rf_write_dest, rf_write_data, dest_e, dat_e);
        end
      end
      if (chk_e) begin
        tests_run++;
        if (rf_read_addr_1 !== dest_e) begin
          tests_failed++;
          $display("FAIL %s c%0d read_addr: got %0d expected %0d", tag, c, rf_read_addr_1, dest_e);
        end
      end
      if (c == 1) begin
        tests_run++;
        if ({irst_fail, irst_fail_addr} !== 4'b0000) begin
          tests_failed++;
          $display("FAIL %s fail_cleared_on_start: got fail=%b addr=%0d expected 0/0",
                   tag, irst_fail, irst_fail_addr);
        end
      end
    end
    fault_active  = 1'b0;
    pipe_write_en = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if ({irst_busy, irst_done, mem[0]} !== {2'b00, 16'h0000}) begin
      tests_failed++;
      $display("FAIL %s after_done: got busy=%b done=%b entry0=%h expected 0 0 0000",
               tag, irst_busy, irst_done, mem[0]);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({irst_busy, irst_done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL %s no_retrigger: got busy=%b done=%b expected 0 0", tag, irst_busy, irst_done);
    end
    model_fail(s, fault, exp_f, exp_fa);
    tests_run++;
    if ({irst_fail, irst_fail_addr} !== {exp_f, exp_fa}) begin
      tests_failed++;
      $display("FAIL %s fail_result: got fail=%b addr=%0d expected fail=%b addr=%0d",
               tag, irst_fail, irst_fail_addr, exp_f, exp_fa);
    end
    nz = 1'b0;
    for (int i = 1; i < 8; i++) nz = nz | (|mem[i]);
    tests_run++;
    if (nz !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s cleared_entries: got nonzero=%b expected 0", tag, nz);
    end
  endtask

  // Launches a test through a pipeline write to entry 0, then follows it.
  task automatic run_sequence(input logic [7:0] s, input bit fault, input string tag);
    pipe_write_en    = 1'b1;
    pipe_write_dest  = 3'd0;
    pipe_write_data  = {8'h80, s};
    pipe_read_addr_1 = 3'd0;
    #1;
    tests_run++;
    if ({irst_busy, rf_write_en, rf_write_dest, rf_write_data} !== {1'b0, 1'b1, 3'd0, 8'h80, s}) begin
      tests_failed++;
      $display("FAIL %s launch_write: got busy=%b en=%b dest=%0d data=%h expected 0 1 0 %h",
               tag, irst_busy, rf_write_en, rf_write_dest, rf_write_data, {8'h80, s});
    end
    @(negedge clk);
    follow_sequence(s, fault, tag);
  endtask

  task automatic test_reset;
    logic [15:0] x;
    rst = 1'b0;
    rf_clear_req = 1'b1;
    fault_active = 1'b0;
    pipe_write_en = 1'b0;
    pipe_write_dest = 3'd0;
    pipe_write_data = 16'h0000;
    pipe_read_addr_1 = 3'd0;
    repeat (3) @(negedge clk);
    x = 16'($urandom);
    pipe_write_en = 1'b1;
    pipe_write_dest = 3'd2;
    pipe_write_data = x;
    pipe_read_addr_1 = 3'd6;
    #1;
    tests_run++;
    if ({irst_busy, pipe_stall, irst_done, irst_fail, irst_fail_addr} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b stall=%b done=%b fail=%b addr=%0d expected all 0",
               irst_busy, pipe_stall, irst_done, irst_fail, irst_fail_addr);
    end
    tests_run++;
    if ({rf_write_en, rf_write_dest, rf_write_data, rf_read_addr_1} !== {1'b1, 3'd2, x, 3'd6}) begin
      tests_failed++;
      $display("FAIL reset_passthrough: got en=%b dest=%0d data=%h raddr=%0d expected 1 2 %h 6",
               rf_write_en, rf_write_dest, rf_write_data, rf_read_addr_1, x);
    end
    pipe_write_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rf_clear_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_passthrough;
    logic        en;
    logic [2:0]  d, r;
    logic [15:0] x;
    for (int i = 0; i < 8; i++) begin
      en = 1'($urandom);
      d  = 3'($urandom);
      x  = (d == 3'd0) ? (16'($urandom) & 16'h7FFF) : 16'($urandom);
      r  = 3'($urandom);
      pipe_write_en = en;
      pipe_write_dest = d;
      pipe_write_data = x;
      pipe_read_addr_1 = r;
      #1;
      tests_run++;
      if ({irst_busy, rf_write_en, rf_write_dest, rf_write_data, rf_read_addr_1} !== {1'b0, en, d, x, r}) begin
        tests_failed++;
        $display("FAIL idle_passthrough: got busy=%b en=%b dest=%0d data=%h raddr=%0d expected 0 %b %0d %h %0d",
                 irst_busy, rf_write_en, rf_write_dest, rf_write_data, rf_read_addr_1, en, d, x, r);
      end
      @(negedge clk);
    end
    pipe_write_en = 1'b0;
    #1;
    tests_run++;
    if (irst_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_start: got busy=%b expected 0", irst_busy);
    end
  endtask

  task automatic test_basic;
    run_sequence(8'h0F, 1'b0, "basic");
  endtask

  task automatic test_fault;
    run_sequence(8'($urandom) & 8'hFE, 1'b1, "fault");
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({irst_fail, irst_fail_addr} !== {1'b1, 3'd3}) begin
      tests_failed++;
      $display("FAIL fault_hold: got fail=%b addr=%0d expected 1 3", irst_fail, irst_fail_addr);
    end
  endtask

  task automatic test_pattern55;
    run_sequence(8'h55, 1'b0, "p55");
  endtask

  task automatic test_abort;
    pipe_write_en = 1'b1;
    pipe_write_dest = 3'd0;
    pipe_write_data = 16'h8F0F;
    @(negedge clk);
    pipe_write_en = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if ({irst_busy, irst_done} !== 2'b10) begin
        tests_failed++;
        $display("FAIL abort_run c%0d: got busy=%b done=%b expected 1 0", c, irst_busy, irst_done);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({irst_busy, pipe_stall, irst_done, rf_write_en} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL abort_in_reset: got busy=%b stall=%b done=%b we=%b expected 0 0 0 0",
               irst_busy, pipe_stall, irst_done, rf_write_en);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({irst_busy, irst_done, mem[0], mem[3]} !== {2'b00, 16'h8F0F, 16'h0F0C}) begin
      tests_failed++;
      $display("FAIL abort_after: got busy=%b done=%b entry0=%h entry3=%h expected 0 0 8f0f 0f0c",
               irst_busy, irst_done, mem[0], mem[3]);
    end
    follow_sequence(8'h0F, 1'b0, "abort_restart");
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      run_sequence(8'($urandom), 1'($urandom), "random");
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_basic();
    test_fault();
    test_pattern55();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
